// File: rtl/sha256_pkg.sv
// Shared SHA-256 host/core definitions: block and digest widths, host FSM states, IVs.
package sha256_pkg;

    localparam int unsigned BLOCK_W  = 512;
    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned WORD_W   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StDrain
    } host_state_e;

    // H0..H7 initial hash values; the core loads these when core_init is set.
    localparam logic [DIGEST_W-1:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

endpackage

// File: rtl/sha256_digest_serializer.sv
// Captures the final 256-bit digest and streams it out MSB-first in DATA_W-bit beats
// under valid/ready flow control.
module sha256_digest_serializer
    import sha256_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [DIGEST_W-1:0] i_hash,
    input  logic                i_out_ready,
    output logic                o_out_valid,
    output logic [DATA_W-1:0]   o_out_data,
    output logic                o_out_last,
    output logic                o_done
);

    localparam int unsigned OUT_BEATS = DIGEST_W / DATA_W;
    localparam int unsigned CNT_W     = $clog2(OUT_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(OUT_BEATS - 1);

    logic [DIGEST_W-1:0] r_digest;
    logic [CNT_W-1:0]    r_beat;
    logic                r_valid;
    logic                w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digest <= '0;
            r_beat   <= '0;
            r_valid  <= 1'b0;
        end else if (i_load) begin
            r_digest <= i_hash;
            r_beat   <= '0;
            r_valid  <= 1'b1;
        end else if (r_valid && i_out_ready) begin
            // Shift so the current beat always sits in the top DATA_W bits.
            r_digest <= r_digest << DATA_W;
            if (r_beat == LAST_BEAT) begin
                r_beat  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_beat <= r_beat + CNT_W'(1);
            end
        end
    end

    assign w_last      = r_valid && (r_beat == LAST_BEAT);
    assign o_out_valid = r_valid;
    assign o_out_data  = r_digest[DIGEST_W-1 -: DATA_W];
    assign o_out_last  = w_last;
    assign o_done      = w_last && i_out_ready;

endmodule

// File: rtl/sha256_stream_host.sv
// Host front end for the SHA-256 core: packs input beats into 512-bit blocks, chains
// multi-block messages, serialises the digest and compares it against a golden value.
module sha256_stream_host
    import sha256_pkg::*;
#(
    parameter int unsigned          DATA_W = 16,
    parameter logic [DIGEST_W-1:0]  EXPECT =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [DATA_W-1:0]   i_in_data,
    input  logic                i_in_last,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [DATA_W-1:0]   o_out_data,
    output logic                o_out_last,
    output logic                o_core_init,
    output logic                o_core_start,
    output logic [BLOCK_W-1:0]  o_core_block,
    input  logic                i_core_done,
    input  logic [DIGEST_W-1:0] i_core_hash,
    output logic                o_match,
    output logic                o_match_valid,
    output logic                o_err
);

    localparam int unsigned IN_BEATS = BLOCK_W / DATA_W;
    localparam int unsigned CNT_W    = $clog2(IN_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_BEATS - 1);

    host_state_e        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BLOCK_W-1:0] r_block;
    logic               r_first;
    logic               r_final;
    logic               r_in_ready;
    logic               r_start;
    logic               r_init;
    logic               r_match;
    logic               r_match_valid;
    logic               r_err;
    logic               w_load;
    logic               w_drain_done;

    assign w_load = (r_state == StRun) && i_core_done && r_final;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_block       <= '0;
            r_first       <= 1'b1;
            r_final       <= 1'b0;
            r_in_ready    <= 1'b0;
            r_start       <= 1'b0;
            r_init        <= 1'b0;
            r_match       <= 1'b0;
            r_match_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_init  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_state    <= StFill;
                    r_in_ready <= 1'b1;
                end
                StFill: begin
                    if (i_in_valid && r_in_ready) begin
                        // Shifting in from the bottom leaves beat 0 in the top bits.
                        r_block <= {r_block[BLOCK_W-DATA_W-1:0], i_in_data};
                        if (r_first && (r_cnt == '0)) begin
                            r_match       <= 1'b0;
                            r_match_valid <= 1'b0;
                        end
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt      <= '0;
                            r_start    <= 1'b1;
                            r_init     <= r_first;
                            r_final    <= i_in_last;
                            r_in_ready <= 1'b0;
                            r_state    <= StRun;
                        end else if (i_in_last) begin
                            // Short message: drop the partial block and resync.
                            r_cnt   <= '0;
                            r_first <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                StRun: begin
                    if (i_core_done) begin
                        if (r_final) begin
                            r_match       <= (i_core_hash == EXPECT);
                            r_match_valid <= 1'b1;
                            r_first       <= 1'b1;
                            r_state       <= StDrain;
                        end else begin
                            r_first    <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= StFill;
                        end
                    end
                end
                StDrain: begin
                    if (w_drain_done) begin
                        r_in_ready <= 1'b1;
                        r_state    <= StFill;
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

    sha256_digest_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_hash      (i_core_hash),
        .i_out_ready (i_out_ready),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last),
        .o_done      (w_drain_done)
    );

    assign o_in_ready    = r_in_ready;
    assign o_core_start  = r_start;
    assign o_core_init   = r_init;
    assign o_core_block  = r_block;
    assign o_match       = r_match;
    assign o_match_valid = r_match_valid;
    assign o_err         = r_err;

endmodule
